// File: rtl/nw_traceback_walker.sv
// nw_traceback_walker: walks the NW direction matrix from (LEN_A, LEN_B) back
// to (0,0), one RAM read per interior step, and streams path ops downstream.
// Optional feature macro: NW_LOCAL_ALIGN_EN (Smith-Waterman local traceback:
// programmable start cell, sym=000 is a legal STOP, no forced edge ops).
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   start_i                  begin a walk (sampled in IDLE only)
//   start_i_i, start_j_i     start cell (NW_LOCAL_ALIGN_EN only)
//   busy_o, done_o, err_o    status: walking, end-of-walk pulse, sticky error
//   rd_en_o, rd_i_o, rd_j_o  direction RAM read request and address
//   sym_valid_i, sym_i       direction symbol return (DIAG=001 UP=010 LEFT=100)
//   out_valid_o, out_ready_i path op stream handshake
//   out_op_o, out_i_o, out_j_o op (00 DIAG, 01 UP, 10 LEFT) and cell it leaves
//   path_len_o               ops accepted since start
module nw_traceback_walker #(
  parameter int unsigned LEN_A = 128,
  parameter int unsigned LEN_B = 128,
  localparam int unsigned BIT_A = $clog2(LEN_A + 1),
  localparam int unsigned BIT_B = $clog2(LEN_B + 1),
  localparam int unsigned BIT_P = $clog2(LEN_A + LEN_B + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
`ifdef NW_LOCAL_ALIGN_EN
  input  logic [BIT_A-1:0] start_i_i,
  input  logic [BIT_B-1:0] start_j_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             rd_en_o,
  output logic [BIT_A-1:0] rd_i_o,
  output logic [BIT_B-1:0] rd_j_o,
  input  logic             sym_valid_i,
  input  logic [2:0]       sym_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [1:0]       out_op_o,
  output logic [BIT_A-1:0] out_i_o,
  output logic [BIT_B-1:0] out_j_o,
  output logic [BIT_P-1:0] path_len_o
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EMIT, S_DONE} state_t;

  localparam logic [1:0] OP_DIAG = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_LEFT = 2'b10;

  state_t           state_q, state_d;
  logic [BIT_A-1:0] i_q, i_d;
  logic [BIT_B-1:0] j_q, j_d;
  logic [1:0]       op_q, op_d;
  logic             err_q, err_d;
  logic [BIT_P-1:0] path_q, path_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_en_q, rd_en_d;
  logic             valid_q, valid_d;

  // State, walk position and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      op_q    <= OP_DIAG;
      err_q   <= 1'b0;
      path_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      op_q    <= op_d;
      err_q   <= err_d;
      path_q  <= path_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      valid_q <= valid_d;
    end
  end

  // Next-state and walk update; output flops are loaded from the next state so
  // they line up with the state they describe.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    op_d    = op_q;
    err_d   = err_q;
    path_d  = path_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          path_d  = '0;
          err_d   = 1'b0;
          state_d = S_REQ;
`ifdef NW_LOCAL_ALIGN_EN
          i_d = start_i_i;
          j_d = start_j_i;
          if (32'(start_i_i) > LEN_A || 32'(start_j_i) > LEN_B) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
`else
          i_d = BIT_A'(LEN_A);
          j_d = BIT_B'(LEN_B);
`endif
        end
      end
      S_REQ: begin
`ifdef NW_LOCAL_ALIGN_EN
        state_d = S_WAIT;
`else
        // Edge cells need no RAM lookup: the only legal move is along the edge.
        if (i_q == '0 && j_q == '0) begin
          state_d = S_DONE;
        end else if (i_q == '0) begin
          op_d    = OP_LEFT;
          state_d = S_EMIT;
        end else if (j_q == '0) begin
          op_d    = OP_UP;
          state_d = S_EMIT;
        end else begin
          state_d = S_WAIT;
        end
`endif
      end
      S_WAIT: begin
        if (sym_valid_i) begin
          state_d = S_EMIT;
          // Multi-hot symbols resolve DIAG > UP > LEFT.
          if (sym_i[0]) begin
            op_d = OP_DIAG;
          end else if (sym_i[1]) begin
            op_d = OP_UP;
          end else if (sym_i[2]) begin
            op_d = OP_LEFT;
          end else begin
            state_d = S_DONE;
`ifndef NW_LOCAL_ALIGN_EN
            err_d = 1'b1;
`endif
          end
`ifdef NW_LOCAL_ALIGN_EN
          // A move off the matrix edge is a corrupt direction RAM.
          if ((sym_i[0] && (i_q == '0 || j_q == '0)) ||
              (!sym_i[0] && sym_i[1] && i_q == '0) ||
              (!sym_i[0] && !sym_i[1] && sym_i[2] && j_q == '0)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_EMIT: begin
        if (out_ready_i) begin
          if (op_q != OP_LEFT) i_d = i_q - BIT_A'(1);
          if (op_q != OP_UP)   j_d = j_q - BIT_B'(1);
          path_d  = path_q + BIT_P'(1);
          state_d = S_REQ;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d == S_REQ) || (state_d == S_WAIT) || (state_d == S_EMIT);
    done_d  = (state_d == S_DONE);
    valid_d = (state_d == S_EMIT);
`ifdef NW_LOCAL_ALIGN_EN
    rd_en_d = (state_d == S_REQ);
`else
    rd_en_d = (state_d == S_REQ) && (i_d != '0) && (j_d != '0);
`endif
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rd_en_o     = rd_en_q;
  assign rd_i_o      = i_q;
  assign rd_j_o      = j_q;
  assign out_valid_o = valid_q;
  assign out_op_o    = op_q;
  assign out_i_o     = i_q;
  assign out_j_o     = j_q;
  assign path_len_o  = path_q;

endmodule

// File: tb/tb_nw_traceback_walker.sv
// Directed bench: a 3x5 walker driven by a table-based direction RAM model and
// a 4x4 walker answering DIAG to every read.
module tb_nw_traceback_walker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 3x5 instance
  logic       start_a, busy_a, done_a, err_a, rd_en_a, sym_valid_a, valid_a, ready_a;
  logic [1:0] rd_i_a, out_i_a, op_a;
  logic [2:0] rd_j_a, out_j_a, sym_a;
  logic [3:0] path_a;

  // 4x4 instance
  logic       start_b, busy_b, done_b, err_b, rd_en_b, sym_valid_b, valid_b, ready_b;
  logic [2:0] rd_i_b, out_i_b, rd_j_b, out_j_b, sym_b;
  logic [1:0] op_b;
  logic [3:0] path_b;

  nw_traceback_walker #(.LEN_A(3), .LEN_B(5)) u_dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
    .err_o(err_a), .rd_en_o(rd_en_a), .rd_i_o(rd_i_a), .rd_j_o(rd_j_a),
    .sym_valid_i(sym_valid_a), .sym_i(sym_a), .out_valid_o(valid_a),
    .out_ready_i(ready_a), .out_op_o(op_a), .out_i_o(out_i_a), .out_j_o(out_j_a),
    .path_len_o(path_a)
  );

  nw_traceback_walker #(.LEN_A(4), .LEN_B(4)) u_dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
    .err_o(err_b), .rd_en_o(rd_en_b), .rd_i_o(rd_i_b), .rd_j_o(rd_j_b),
    .sym_valid_i(sym_valid_b), .sym_i(sym_b), .out_valid_o(valid_b),
    .out_ready_i(ready_b), .out_op_o(op_b), .out_i_o(out_i_b), .out_j_o(out_j_b),
    .path_len_o(path_b)
  );

  localparam logic [2:0] S_DIAG = 3'b001;
  localparam logic [2:0] S_UP   = 3'b010;
  localparam logic [2:0] S_LEFT = 3'b100;
  localparam int OD = 0, OU = 1, OL = 2;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0] sym_tab [16];
  int cap [16];
  int n_ops, n_reads, reads_at_release;
  bit done_seen, stall_ok;
  logic busy_start, err_start, fin_busy, fin_err;
  logic [3:0] fin_path;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int code(input int op, input int i, input int j);
    return op * 256 + i * 16 + j;
  endfunction

  function automatic int code_a();
    return code(int'(op_a), int'(out_i_a), int'(out_j_a));
  endfunction

  task automatic fill_tab(input logic [2:0] s);
    for (int n = 0; n < 16; n++) sym_tab[n] = s;
  endtask

  // One walk on the 3x5 instance. RAM answers lat cycles after each read; the
  // first EMIT is held off for stall_len cycles.
  task automatic walk_a(input int lat, input int stall_len);
    int cnt, k, cyc, stall_left;
    bit armed, released;
    int ref_v;
    cnt = 0; k = 0; cyc = 0; stall_left = 0; ref_v = 0;
    armed = (stall_len > 0); released = 1'b0;
    n_ops = 0; n_reads = 0; done_seen = 1'b0; stall_ok = 1'b1; reads_at_release = -1;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    busy_start = busy_a; err_start = err_a;
    while (!done_seen && cyc < 500) begin
      sym_valid_a = 1'b0; sym_a = 3'b000;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin sym_valid_a = 1'b1; sym_a = sym_tab[k]; k++; end
      end
      if (rd_en_a) begin n_reads++; cnt = lat; end
      if (done_a) begin
        done_seen = 1'b1; fin_path = path_a; fin_err = err_a; fin_busy = busy_a;
      end
      ready_a = 1'b1;
      if (valid_a) begin
        if (armed) begin armed = 1'b0; stall_left = stall_len; ref_v = code_a(); end
        if (stall_left > 0) begin
          ready_a = 1'b0;
          stall_left--;
          if (code_a() != ref_v || path_a != 4'd0 || rd_en_a) stall_ok = 1'b0;
        end else begin
          if (stall_len > 0 && !released) begin released = 1'b1; reads_at_release = n_reads; end
          if (n_ops < 16) cap[n_ops] = code_a();
          n_ops++;
        end
      end else if (stall_left > 0 && rd_en_a) begin
        stall_ok = 1'b0;
      end
      if (!done_seen) begin @(negedge clk); cyc++; end
    end
    sym_valid_a = 1'b0; ready_a = 1'b1;
    check("walk_a_timeout", int'(done_seen), 1);
  endtask

  // 4x4 walk with a DIAG-only RAM and an always-ready sink.
  task automatic walk_b();
    int cyc;
    bit pend;
    cyc = 0; pend = 1'b0; n_ops = 0; done_seen = 1'b0;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    while (!done_seen && cyc < 500) begin
      sym_valid_b = pend; sym_b = S_DIAG; pend = 1'b0;
      if (rd_en_b) pend = 1'b1;
      if (valid_b) begin
        if (n_ops < 16) cap[n_ops] = code(int'(op_b), int'(out_i_b), int'(out_j_b));
        n_ops++;
      end
      if (done_b) begin done_seen = 1'b1; fin_path = path_b; fin_err = err_b; end
      if (!done_seen) begin @(negedge clk); cyc++; end
    end
    sym_valid_b = 1'b0;
    check("walk_b_timeout", int'(done_seen), 1);
  endtask

  initial begin
    rst = 1'b0;
    start_a = 1'b0; sym_valid_a = 1'b0; sym_a = 3'b000; ready_a = 1'b1;
    start_b = 1'b0; sym_valid_b = 1'b0; sym_b = 3'b000; ready_b = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_err", int'(err_a), 0);
    check("rst_rd_en", int'(rd_en_a), 0);
    check("rst_valid", int'(valid_a), 0);
    check("rst_path", int'(path_a), 0);
    check("rst_out_ij", int'({out_i_a, out_j_a}), 0);
    rst = 1'b1;

    // 4x4, all DIAG
    walk_b();
    check("b_nops", n_ops, 4);
    for (int n = 0; n < 4; n++) check($sformatf("b_op%0d", n), cap[n], code(OD, 4 - n, 4 - n));
    check("b_path", int'(fin_path), 4);
    check("b_err", int'(fin_err), 0);

    // 3x5: LEFT, LEFT, DIAG, DIAG, DIAG
    fill_tab(S_DIAG); sym_tab[0] = S_LEFT; sym_tab[1] = S_LEFT;
    walk_a(1, 0);
    check("t1_busy_start", int'(busy_start), 1);
    check("t1_nops", n_ops, 5);
    check("t1_op0", cap[0], code(OL, 3, 5));
    check("t1_op1", cap[1], code(OL, 3, 4));
    check("t1_op2", cap[2], code(OD, 3, 3));
    check("t1_op3", cap[3], code(OD, 2, 2));
    check("t1_op4", cap[4], code(OD, 1, 1));
    check("t1_reads", n_reads, 5);
    check("t1_path", int'(fin_path), 5);
    check("t1_err", int'(fin_err), 0);
    check("t1_done_busy", int'(fin_busy), 0);
    @(negedge clk);
    check("t1_done_pulse", int'(done_a), 0);

    // all DIAG, latency 2: reaches (0,2) then two forced LEFTs without reads
    fill_tab(S_DIAG);
    walk_a(2, 0);
    check("t2_nops", n_ops, 5);
    check("t2_op2", cap[2], code(OD, 1, 3));
    check("t2_op3", cap[3], code(OL, 0, 2));
    check("t2_op4", cap[4], code(OL, 0, 1));
    check("t2_reads", n_reads, 3);
    check("t2_path", int'(fin_path), 5);

    // back-pressure: out_ready low for 10 cycles on the first op
    walk_a(1, 10);
    check("t3_stall_stable", int'(stall_ok), 1);
    check("t3_reads_at_release", reads_at_release, 1);
    check("t3_op0", cap[0], code(OD, 3, 5));
    check("t3_path", int'(fin_path), 5);

    // illegal symbol on the 2nd read
    fill_tab(S_DIAG); sym_tab[0] = S_LEFT; sym_tab[1] = 3'b000;
    walk_a(1, 0);
    check("t4_err", int'(fin_err), 1);
    check("t4_path", int'(fin_path), 1);
    check("t4_nops", n_ops, 1);
    @(negedge clk);
    check("t4_err_sticky", int'(err_a), 1);

    // multi-hot priority; the new start clears err
    fill_tab(S_DIAG); sym_tab[0] = 3'b110; sym_tab[1] = 3'b101; sym_tab[2] = 3'b111;
    walk_a(1, 0);
    check("t5_err_cleared", int'(err_start), 0);
    check("t5_op0", cap[0], code(OU, 3, 5));
    check("t5_op1", cap[1], code(OD, 2, 5));
    check("t5_op2", cap[2], code(OD, 1, 4));
    check("t5_op5", cap[5], code(OL, 0, 1));
    check("t5_nops", n_ops, 6);
    check("t5_path", int'(fin_path), 6);
    check("t5_err", int'(fin_err), 0);

    // reset while waiting for the RAM, then a fresh walk
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    check("t6_rd_en", int'(rd_en_a), 1);
    check("t6_rd_addr", int'({rd_i_a, rd_j_a}), int'({2'd3, 3'd5}));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_rst_busy", int'(busy_a), 0);
    check("t6_rst_valid", int'({valid_a, rd_en_a, done_a}), 0);
    check("t6_rst_ij", int'({out_i_a, out_j_a}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check("t6_no_done", int'(done_a), 0);
    fill_tab(S_DIAG);
    walk_a(1, 0);
    check("t6_op0", cap[0], code(OD, 3, 5));
    check("t6_path", int'(fin_path), 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
